// File: rtl/pwm_sample_fifo_pkg.sv
// Shared audio constants used by the audio processing unit, the PWM and the sample FIFO.
package pwm_sample_fifo_pkg;

  localparam int unsigned SAMPLE_WIDTH = 9;

  // Mid-scale compare value: 50% duty, i.e. silence
  localparam logic [SAMPLE_WIDTH-1:0] IDLE_COMPARE_VALUE = SAMPLE_WIDTH'(128);

endpackage

// File: rtl/sample_fifo_mem.sv
// Simple dual-port sample storage: synchronous write, asynchronous read, no reset.
module sample_fifo_mem
  import pwm_sample_fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = SAMPLE_WIDTH,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port, combinational so the head entry is available on the read edge
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pwm_sample_fifo.sv
// Rate-decoupling FIFO between the audio sample producer and the PWM compare register.
module pwm_sample_fifo
  import pwm_sample_fifo_pkg::*;
#(
  parameter int unsigned     WIDTH        = SAMPLE_WIDTH,
  parameter int unsigned     DEPTH_LOG2   = 3,
  parameter logic [WIDTH-1:0] IDLE_COMPARE = WIDTH'(IDLE_COMPARE_VALUE)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [WIDTH-1:0]      i_sample,
  input  logic                  i_sample_valid,
  output logic                  o_ready,
  input  logic                  i_cycle_end,
  output logic [WIDTH-1:0]      o_compare,
  output logic                  o_compare_valid,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_underrun,
  output logic                  o_overrun
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned LEVEL_W = DEPTH_LOG2 + 1;
  localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DEPTH);

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [WIDTH-1:0]      head_data;
  logic                  full;
  logic                  empty;
  logic                  wr_en;
  logic                  rd_en;

  // Full/empty come only from the registered level, never from pointer compare
  assign full    = (o_level == FULL_LEVEL);
  assign empty   = (o_level == '0);
  assign o_ready = !full;
  assign wr_en   = i_sample_valid && !full;
  assign rd_en   = i_cycle_end && !empty;

  sample_fifo_mem #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (DEPTH_LOG2)
  ) u_mem (
    .clk     (i_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (i_sample),
    .rd_addr (rd_ptr),
    .rd_data (head_data)
  );

  // Pointers, occupancy, compare register and event pulses
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      o_level         <= '0;
      o_compare       <= IDLE_COMPARE;
      o_compare_valid <= 1'b0;
      o_underrun      <= 1'b0;
      o_overrun       <= 1'b0;
    end else begin
      o_compare_valid <= rd_en;
      o_underrun      <= i_cycle_end && empty;
      o_overrun       <= i_sample_valid && full;
      if (wr_en) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (rd_en) begin
        rd_ptr    <= rd_ptr + DEPTH_LOG2'(1);
        o_compare <= head_data;
      end
      case ({wr_en, rd_en})
        2'b10:   o_level <= o_level + LEVEL_W'(1);
        2'b01:   o_level <= o_level - LEVEL_W'(1);
        default: o_level <= o_level;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_sample_fifo.sv
// Directed testbench for pwm_sample_fifo: vector table plus reset and pointer-wrap sequences.
module tb_pwm_sample_fifo;

  logic       i_clk;
  logic       i_rst;
  logic [8:0] i_sample;
  logic       i_sample_valid;
  logic       o_ready;
  logic       i_cycle_end;
  logic [8:0] o_compare;
  logic       o_compare_valid;
  logic [3:0] o_level;
  logic       o_underrun;
  logic       o_overrun;

  int checks;
  int errors;

  typedef struct {
    logic       valid;
    logic [8:0] sample;
    logic       ce;
    logic [8:0] cmp;
    logic       cv;
    logic [3:0] lvl;
    logic       rdy;
    logic       un;
    logic       ov;
  } vec_t;

  vec_t vecs[$];

  pwm_sample_fifo dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_sample        (i_sample),
    .i_sample_valid  (i_sample_valid),
    .o_ready         (o_ready),
    .i_cycle_end     (i_cycle_end),
    .o_compare       (o_compare),
    .o_compare_valid (o_compare_valid),
    .o_level         (o_level),
    .o_underrun      (o_underrun),
    .o_overrun       (o_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int cmp, input int cv, input int lvl,
                         input int rdy, input int un, input int ov);
    chk({tag, " compare"},       int'(o_compare),       cmp);
    chk({tag, " compare_valid"}, int'(o_compare_valid), cv);
    chk({tag, " level"},         int'(o_level),         lvl);
    chk({tag, " ready"},         int'(o_ready),         rdy);
    chk({tag, " underrun"},      int'(o_underrun),      un);
    chk({tag, " overrun"},       int'(o_overrun),       ov);
  endtask

  function automatic void add(input logic valid, input int sample, input logic ce,
                              input int cmp, input logic cv, input int lvl,
                              input logic rdy, input logic un, input logic ov);
    vec_t v;
    v.valid  = valid;
    v.sample = 9'(sample);
    v.ce     = ce;
    v.cmp    = 9'(cmp);
    v.cv     = cv;
    v.lvl    = 4'(lvl);
    v.rdy    = rdy;
    v.un     = un;
    v.ov     = ov;
    vecs.push_back(v);
  endfunction

  // Apply inputs for one clock, then sample 1 time unit after the edge
  task automatic cycle(input logic valid, input int sample, input logic ce);
    i_sample_valid = valid;
    i_sample       = 9'(sample);
    i_cycle_end    = ce;
    @(posedge i_clk);
    #1;
    i_sample_valid = 1'b0;
    i_cycle_end    = 1'b0;
  endtask

  function automatic int wrap_val(input int idx);
    if (idx == 0) return 0;
    if (idx == 1) return 9'h1FF;
    return (idx * 37 + 11) & 9'h1FF;
  endfunction

  initial begin
    checks         = 0;
    errors         = 0;
    i_rst          = 1'b1;
    i_sample       = '0;
    i_sample_valid = 1'b0;
    i_cycle_end    = 1'b0;

    // Values held during reset
    #2;
    chk_all("in_reset", 128, 0, 0, 1, 0, 0);
    #10;
    i_rst = 1'b0;

    // Vector table: valid, sample, cycle_end -> compare, cv, level, ready, underrun, overrun
    add(0, 0,  0, 128, 0, 0, 1, 0, 0);
    add(0, 0,  1, 128, 0, 0, 1, 1, 0);  // underrun on empty after reset
    add(0, 0,  0, 128, 0, 0, 1, 0, 0);
    add(1, 10, 0, 128, 0, 1, 1, 0, 0);
    add(1, 20, 0, 128, 0, 2, 1, 0, 0);
    add(1, 30, 0, 128, 0, 3, 1, 0, 0);
    add(0, 0,  1, 10,  1, 2, 1, 0, 0);
    add(0, 0,  1, 20,  1, 1, 1, 0, 0);
    add(0, 0,  1, 30,  1, 0, 1, 0, 0);
    add(0, 0,  0, 30,  0, 0, 1, 0, 0);  // compare holds
    add(0, 0,  1, 30,  0, 0, 1, 1, 0);  // underrun keeps last compare
    for (int i = 1; i <= 8; i++) add(1, i, 0, 30, 0, i, (i != 8), 0, 0);
    add(1, 9,  0, 30,  0, 8, 0, 0, 1);  // dropped while full
    add(0, 0,  0, 30,  0, 8, 0, 0, 0);
    add(1, 99, 1, 1,   1, 7, 1, 0, 1);  // full: read proceeds, write rejected
    for (int k = 2; k <= 8; k++) add(0, 0, 1, k, 1, 8 - k, 1, 0, 0);  // held cycle_end
    add(0, 0,  0, 8,   0, 0, 1, 0, 0);
    add(1, 5,  0, 8,   0, 1, 1, 0, 0);
    add(1, 6,  1, 5,   1, 1, 1, 0, 0);  // simultaneous read/write
    add(0, 0,  1, 6,   1, 0, 1, 0, 0);
    add(1, 7,  1, 6,   0, 1, 1, 1, 0);  // empty + write: underrun, no bypass
    add(0, 0,  1, 7,   1, 0, 1, 0, 0);

    foreach (vecs[n]) begin
      cycle(vecs[n].valid, int'(vecs[n].sample), vecs[n].ce);
      chk_all($sformatf("vec%0d", n), int'(vecs[n].cmp), int'(vecs[n].cv),
              int'(vecs[n].lvl), int'(vecs[n].rdy), int'(vecs[n].un), int'(vecs[n].ov));
    end

    // Pointer wrap: fill 4, drain 4, five rounds
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) begin
        cycle(1'b1, wrap_val(r * 4 + i), 1'b0);
        chk($sformatf("wrap r%0d fill level", r), int'(o_level), i + 1);
      end
      for (int i = 0; i < 4; i++) begin
        cycle(1'b0, 0, 1'b1);
        chk($sformatf("wrap r%0d rd%0d compare", r, i), int'(o_compare), wrap_val(r * 4 + i));
        chk($sformatf("wrap r%0d rd%0d valid", r, i), int'(o_compare_valid), 1);
      end
      chk($sformatf("wrap r%0d empty level", r), int'(o_level), 0);
    end

    // Asynchronous reset with samples stored and a valid pulse active
    for (int i = 0; i < 6; i++) cycle(1'b1, 100 + i, 1'b0);
    cycle(1'b0, 0, 1'b1);
    chk_all("pre_reset", 100, 1, 5, 1, 0, 0);
    #2;
    i_rst = 1'b1;
    #1;
    chk_all("async_reset", 128, 0, 0, 1, 0, 0);
    @(posedge i_clk);
    #1;
    chk_all("reset_hold", 128, 0, 0, 1, 0, 0);
    #2;
    i_rst = 1'b0;
    cycle(1'b1, 77, 1'b1);
    chk_all("post_reset_first", 128, 0, 1, 1, 1, 0);
    cycle(1'b0, 0, 1'b1);
    chk_all("post_reset_read", 77, 1, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_sample_fifo.md
PWM_SAMPLE_FIFO -- requirements
Module: pwm_sample_fifo

Purpose: rate-decoupling buffer between the audio processing unit's sample output and the PWM compare input. One sample is presented per PWM cycle end.

Interface
REQ-001 Parameter WIDTH, default 9, sample/compare width in bits.
REQ-002 Parameter DEPTH_LOG2, default 3, log2 of FIFO depth (8 entries).
REQ-003 Parameter IDLE_COMPARE, default 9'd128, compare value after reset (mid-scale, no pop).
REQ-004 i_clk  input  1  sole clock; all state on rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_sample  input  WIDTH  sample from the audio processing unit.
REQ-007 i_sample_valid  input  1  i_sample is offered this cycle.
REQ-008 o_ready  output  1  FIFO can accept a sample this cycle.
REQ-009 i_cycle_end  input  1  PWM cycle-end strobe (request for next compare value).
REQ-010 o_compare  output  WIDTH  registered compare value to the PWM.
REQ-011 o_compare_valid  output  1  one-cycle pulse when o_compare was loaded from the FIFO.
REQ-012 o_level  output  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.
REQ-013 o_underrun  output  1  one-cycle pulse: cycle end with FIFO empty.
REQ-014 o_overrun  output  1  one-cycle pulse: valid sample offered while full.

Function
REQ-015 o_ready SHALL equal (o_level != 2^DEPTH_LOG2), combinational from registered level only.
REQ-016 Write: i_sample_valid && o_ready stores i_sample at write pointer; pointer increments modulo depth.
REQ-017 Overrun: i_sample_valid && !o_ready drops the sample, asserts o_overrun next cycle; no state changes.
REQ-018 Read: i_cycle_end with o_level != 0 loads head entry into o_compare on that edge (1-cycle latency); o_compare_valid high for that one following cycle; read pointer increments modulo depth.
REQ-019 Underrun: i_cycle_end with o_level == 0 holds o_compare unchanged, o_compare_valid stays 0, o_underrun pulses next cycle.
REQ-020 Simultaneous write and read, non-empty and non-full: both occur, o_level unchanged.
REQ-021 Full with simultaneous read: write still rejected (o_ready already 0), read proceeds, level decrements by 1, o_overrun pulses if valid was high.
REQ-022 Empty with simultaneous write: underrun reported, written sample stored (no bypass), level becomes 1.
REQ-023 o_compare holds its value between reads indefinitely.
REQ-024 Pointers are DEPTH_LOG2 bits and wrap silently; full/empty derived from o_level, never from pointer compare.
REQ-025 i_cycle_end held high for multiple cycles SHALL read once per cycle (no edge detection).

Reset
REQ-026 While i_rst high: o_level=0, pointers=0, o_compare=IDLE_COMPARE, o_compare_valid=0, o_underrun=0, o_overrun=0; o_ready=1.
REQ-027 Reset mid-operation discards all stored samples; storage contents need not be cleared.
REQ-028 First write accepted on the first rising edge after i_rst deasserts.

Structure
REQ-029 Sample width constant (9) and IDLE_COMPARE value live in the shared audio package/header used by the audio processing unit and the PWM.
REQ-030 Storage SHALL be one sub-module, sample_fifo_mem (simple dual-port, synchronous write, asynchronous read, no reset), inferable as distributed RAM.
REQ-031 Pointers, level, flags and o_compare register stay in pwm_sample_fifo.

Verification
REQ-032 Reset release, no writes, i_cycle_end pulse -> o_compare=128, o_underrun one pulse, o_compare_valid=0.
REQ-033 Write 10,20,30, then three i_cycle_end pulses -> o_compare 10,20,30 each one cycle after its strobe, o_compare_valid pulse each, o_level 3->0.
REQ-034 Write 9 samples 1..9 with no reads -> o_ready=0 after 8th, sample 9 dropped, o_overrun one pulse, o_level=8; eight reads return 1..8.
REQ-035 Full FIFO, i_sample_valid and i_cycle_end same cycle -> head read out, new sample rejected, o_overrun pulse, o_level=7.
REQ-036 Fill 4, read 4, repeat 5 times (pointer wrap) -> FIFO order preserved, values 0x000 and 0x1FF pass intact.
REQ-037 Assert i_rst asynchronously with o_level=5 -> o_level=0, o_compare=128 immediately, no output pulses; next read underruns.
